// File: rtl/demux_grant_arbiter.sv
// demux_grant_arbiter: round-robin arbiter and sequencer for the shared
// nbit_demux steering path. It grants one requester at a time and holds the
// grant until Done, until the request drops, or until the hold limit expires.
module demux_grant_arbiter #(
  parameter int SELECT_WIDTH = 4,
  parameter int HOLD_LIMIT   = 16
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic [2**SELECT_WIDTH-1:0]   Req,
  input  logic                         Done,
  output logic [SELECT_WIDTH-1:0]      DeMuxSel,
  output logic                         DeMuxEn,
  output logic [2**SELECT_WIDTH-1:0]   Grant,
  output logic                         Busy,
  output logic                         Timeout
);

  localparam int N  = 2**SELECT_WIDTH;
  localparam int HW = (HOLD_LIMIT > 0) ? $clog2(HOLD_LIMIT + 1) : 1;

  typedef enum logic [1:0] {
    stIdle,
    stGrant,
    stRelease
  } stateT;

  stateT                   state, stateNext;
  logic [SELECT_WIDTH-1:0] ptrQ, ptrNext;
  logic [SELECT_WIDTH-1:0] selNext;
  logic [HW-1:0]           holdQ, holdNext;
  logic                    flagQ, flagNext;
  logic                    enNext, busyNext, timeoutNext;
  logic [N-1:0]            grantNext;
  logic                    found;
  logic [SELECT_WIDTH-1:0] pick, idx;

  // Register state, internal counters and every output.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state    <= stIdle;
      ptrQ     <= '0;
      holdQ    <= '0;
      flagQ    <= 1'b0;
      DeMuxSel <= '0;
      DeMuxEn  <= 1'b0;
      Grant    <= '0;
      Busy     <= 1'b0;
      Timeout  <= 1'b0;
    end else begin
      state    <= stateNext;
      ptrQ     <= ptrNext;
      holdQ    <= holdNext;
      flagQ    <= flagNext;
      DeMuxSel <= selNext;
      DeMuxEn  <= enNext;
      Grant    <= grantNext;
      Busy     <= busyNext;
      Timeout  <= timeoutNext;
    end
  end

  // Round-robin search: first requester at or after ptrQ, wrapping modulo N.
  always_comb begin
    found = 1'b0;
    pick  = ptrQ;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = ptrQ + SELECT_WIDTH'(i);
      if (!found && Req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Next-state logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    stateNext = state;
    ptrNext   = ptrQ;
    selNext   = DeMuxSel;
    holdNext  = holdQ;
    flagNext  = flagQ;
    case (state)
      stIdle: begin
        if (found) begin
          selNext   = pick;
          holdNext  = '0;
          flagNext  = 1'b0;
          stateNext = stGrant;
        end
      end
      stGrant: begin
        if (Done) begin
          flagNext  = 1'b0;
          stateNext = stRelease;
        end else if (!Req[DeMuxSel]) begin
          flagNext  = 1'b0;
          stateNext = stRelease;
        end else if ((HOLD_LIMIT != 0) && (holdQ == HW'(HOLD_LIMIT - 1))) begin
          flagNext  = 1'b1;
          stateNext = stRelease;
        end else if (holdQ != '1) begin
          holdNext  = holdQ + 1'b1;
        end
      end
      stRelease: begin
        ptrNext   = DeMuxSel + 1'b1;
        stateNext = stIdle;
      end
      default: stateNext = stIdle;
    endcase
    enNext      = (stateNext == stGrant);
    grantNext   = enNext ? (N'(1) << selNext) : '0;
    busyNext    = (stateNext != stIdle);
    timeoutNext = (stateNext == stRelease) && flagNext;
  end

endmodule

// File: tb/tb_demux_grant_arbiter.sv
// Directed self-checking bench for demux_grant_arbiter (SELECT_WIDTH=4, HOLD_LIMIT=8).
module tb_demux_grant_arbiter;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [15:0] Req;
  logic        Done;
  logic [3:0]  DeMuxSel;
  logic        DeMuxEn;
  logic [15:0] Grant;
  logic        Busy;
  logic        Timeout;

  int nChecks = 0;
  int nFail   = 0;

  demux_grant_arbiter #(
    .SELECT_WIDTH(4),
    .HOLD_LIMIT  (8)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Req     (Req),
    .Done    (Done),
    .DeMuxSel(DeMuxSel),
    .DeMuxEn (DeMuxEn),
    .Grant   (Grant),
    .Busy    (Busy),
    .Timeout (Timeout)
  );

  always #5 Clk = ~Clk;

  // Single comparison point: counts and reports.
  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkAll(input string tag, input logic [15:0] g, input logic [3:0] s,
                          input logic en, input logic b, input logic t);
    checkVal({tag, ".Grant"},    32'(Grant),    32'(g));
    checkVal({tag, ".DeMuxSel"}, 32'(DeMuxSel), 32'(s));
    checkVal({tag, ".DeMuxEn"},  32'(DeMuxEn),  32'(en));
    checkVal({tag, ".Busy"},     32'(Busy),     32'(b));
    checkVal({tag, ".Timeout"},  32'(Timeout),  32'(t));
  endtask

  logic [3:0] rrSeq [5];

  initial begin
    // Reset with everything asserted
    Reset_n = 1'b0; Req = 16'hFFFF; Done = 1'b1;
    tick(); tick();
    checkAll("reset", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);
    Reset_n = 1'b1; Done = 1'b0;
    tick();
    checkAll("firstGrant", 16'h0001, 4'd0, 1'b1, 1'b1, 1'b0);
    Req = 16'h0000; Done = 1'b1;
    tick();
    checkAll("firstRel", 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0);
    Done = 1'b0;
    tick();
    checkAll("firstIdle", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);

    // Single requester, Done on 3rd GRANT cycle
    Req = 16'h0010;
    tick();
    for (int c = 1; c <= 3; c++) begin
      checkAll($sformatf("single.c%0d", c), 16'h0010, 4'd4, 1'b1, 1'b1, 1'b0);
      if (c == 3) Done = 1'b1;
      tick();
    end
    checkAll("single.rel", 16'h0000, 4'd4, 1'b0, 1'b1, 1'b0);
    Done = 1'b0; Req = 16'h0000;
    tick();
    checkAll("single.idle", 16'h0000, 4'd4, 1'b0, 1'b0, 1'b0);
    // Ptr should now be 5: among {0,4,5} index 5 wins
    Req = 16'h0031;
    tick();
    checkAll("ptr5", 16'h0020, 4'd5, 1'b1, 1'b1, 1'b0);
    Done = 1'b1;
    tick();
    Done = 1'b0; Req = 16'h0000;
    tick();

    // Round robin with wrap from a fresh pointer
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    rrSeq[0] = 4'd0; rrSeq[1] = 4'd1; rrSeq[2] = 4'd15; rrSeq[3] = 4'd0; rrSeq[4] = 4'd1;
    Req = 16'h8003;
    for (int k = 0; k < 5; k++) begin
      tick();
      checkAll($sformatf("rr%0d.grant", k), 16'h0001 << rrSeq[k], rrSeq[k], 1'b1, 1'b1, 1'b0);
      Done = 1'b1;
      tick();
      checkAll($sformatf("rr%0d.rel", k), 16'h0000, rrSeq[k], 1'b0, 1'b1, 1'b0);
      Done = 1'b0;
      tick();
      checkAll($sformatf("rr%0d.gap", k), 16'h0000, rrSeq[k], 1'b0, 1'b0, 1'b0);
    end
    Req = 16'h0000;

    // Timeout: 8-cycle hold then one Timeout pulse
    Req = 16'h0100;
    tick();
    for (int c = 1; c <= 8; c++) begin
      checkAll($sformatf("to.c%0d", c), 16'h0100, 4'd8, 1'b1, 1'b1, 1'b0);
      tick();
    end
    checkAll("to.rel", 16'h0000, 4'd8, 1'b0, 1'b1, 1'b1);
    tick();
    checkAll("to.idle", 16'h0000, 4'd8, 1'b0, 1'b0, 1'b0);
    tick();
    checkAll("to.regrant", 16'h0100, 4'd8, 1'b1, 1'b1, 1'b0);

    // Done on the 8th GRANT cycle beats the hold limit
    for (int c = 1; c <= 8; c++) begin
      checkVal($sformatf("doneAt8.c%0d.DeMuxEn", c), 32'(DeMuxEn), 32'd1);
      if (c == 8) Done = 1'b1;
      tick();
    end
    checkAll("doneAt8.rel", 16'h0000, 4'd8, 1'b0, 1'b1, 1'b0);
    Done = 1'b0;
    tick();

    // Request drop together with Done is a normal release
    tick();
    checkAll("dropDone.grant", 16'h0100, 4'd8, 1'b1, 1'b1, 1'b0);
    Req = 16'h0000; Done = 1'b1;
    tick();
    checkAll("dropDone.rel", 16'h0000, 4'd8, 1'b0, 1'b1, 1'b0);
    Done = 1'b0;
    tick();

    // Request drops alone on grant cycle 2
    Req = 16'h0100;
    tick();
    checkVal("drop.c1.DeMuxEn", 32'(DeMuxEn), 32'd1);
    tick();
    checkVal("drop.c2.DeMuxEn", 32'(DeMuxEn), 32'd1);
    Req = 16'h0000;
    tick();
    checkAll("drop.rel", 16'h0000, 4'd8, 1'b0, 1'b1, 1'b0);
    tick();

    // Reset during cycle 4 of a grant to index 6 (pointer 9 wraps round to 6)
    Req = 16'h0040;
    tick();
    checkAll("midRst.grant", 16'h0040, 4'd6, 1'b1, 1'b1, 1'b0);
    tick(); tick(); tick();
    checkVal("midRst.c4.DeMuxEn", 32'(DeMuxEn), 32'd1);
    Reset_n = 1'b0;
    tick();
    checkAll("midRst.reset", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);
    Reset_n = 1'b1; Req = 16'h0041;
    tick();
    checkAll("midRst.after", 16'h0001, 4'd0, 1'b1, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/demux_grant_arbiter.md
# demux_grant_arbiter

Round-robin arbiter and sequencer for the shared `nbit_demux` steering path. It accepts up to 2**SELECT_WIDTH requesters and picks one. It then drives the demux select and enable and holds the grant until the downstream resource signals completion. A hold-limit counter revokes grants that never complete. It sits in the multicycle datapath between the requesting units and the demux instance.

## Interface
- SELECT_WIDTH, 4, width of DeMuxSel; requester count N = 2**SELECT_WIDTH
- HOLD_LIMIT, 16, maximum cycles a grant is held without Done; 0 disables the timeout
- Clk  input  1  single clock; all state updates on rising edge
- Reset_n  input  1  synchronous, active-low reset; sampled on rising edge of Clk
- Req  input  N  per-requester request, level-sensitive
- Done  input  1  completion from the granted resource, sampled only in GRANT
- DeMuxSel  output  SELECT_WIDTH  registered index of current grantee; drives demux select
- DeMuxEn  output  1  registered; high only in GRANT; drives demux data-in
- Grant  output  N  registered one-hot grant; equals DeMuxEn << DeMuxSel
- Busy  output  1  high in GRANT and RELEASE
- Timeout  output  1  one-cycle pulse in RELEASE when the grant ended by hold limit

## Operation
- States: IDLE, GRANT, RELEASE; encoding is free. Reset state is IDLE.
- Internal registers:
  - Ptr (SELECT_WIDTH bits): round-robin start point.
  - HoldCnt: width $clog2(HOLD_LIMIT+1), minimum 1.
  - TimeoutFlag.
- IDLE:
  - If Req != 0, choose the lowest index i at or after Ptr, searching modulo N with wrap from N-1 to 0.
  - Load DeMuxSel=i and HoldCnt=0, then go to GRANT.
  - If Req == 0, stay in IDLE; DeMuxSel holds its last value.
- GRANT: Grant[DeMuxSel]=1 and DeMuxEn=1. HoldCnt increments each cycle. Exit conditions, highest priority first:
  1. Done=1: go to RELEASE with Timeout=0. This is normal completion, even if Req[DeMuxSel] drops in the same cycle.
  2. Req[DeMuxSel]=0: abort; go to RELEASE with Timeout=0.
  3. HOLD_LIMIT != 0 and HoldCnt == HOLD_LIMIT-1: go to RELEASE with Timeout=1.
  4. Otherwise stay in GRANT.
- RELEASE:
  - Grant=0, DeMuxEn=0, Busy=1, and Timeout is driven from TimeoutFlag.
  - Ptr = DeMuxSel+1, wrapping modulo N (N-1 wraps to 0).
  - Unconditionally go to IDLE.
- Req bits other than the grantee are ignored during GRANT and RELEASE; there is no preemption.
- Done is ignored outside GRANT.
- Width rules:
  - Ptr and DeMuxSel wrap naturally at SELECT_WIDTH bits.
  - HoldCnt never exceeds HOLD_LIMIT-1.
  - With HOLD_LIMIT=0, HoldCnt may saturate and has no effect.

## Timing
- Reset values: DeMuxSel=0, DeMuxEn=0, Grant=0, Busy=0, Timeout=0, Ptr=0, HoldCnt=0, state IDLE.
- Reset asserted in any state, including mid-GRANT, returns the block to reset values at that edge. No Timeout pulse is produced.
- Request to grant latency: Req sampled high in IDLE at edge k gives Grant, DeMuxEn and DeMuxSel valid after edge k.
- Grant duration:
  - Done sampled at the m-th GRANT edge means Grant is high for exactly m cycles.
  - A timeout grant lasts exactly HOLD_LIMIT cycles.
- Turnaround: Done sampled at edge e gives RELEASE during cycle e..e+1 and IDLE at e+1. The next grant is visible after edge e+2, a minimum 2-cycle gap.
- Fairness: under continuous requests, every requester is granted within N grant slots.
- All outputs are registered; there are no combinational paths from Req or Done to outputs.

## Test plan
Parameters for all scenarios: SELECT_WIDTH=4, HOLD_LIMIT=8.
- **Reset:** Reset_n=0 for 2 cycles with Req=16'hFFFF and Done=1 -> all outputs 0. First grant after release goes to index 0.
- **Single requester:** Req=16'h0010 from IDLE, Done pulsed on the 3rd GRANT cycle -> after 1 cycle Grant=16'h0010, DeMuxSel=4, DeMuxEn=1 for exactly 3 cycles. Then 1 RELEASE cycle with Busy=1, Timeout=0, and Ptr=5.
- **Round robin with wrap:** Req=16'h8003 held, Done asserted on the 1st GRANT cycle each time -> grant sequence DeMuxSel=0,1,15,0,1. Each grant is 1 cycle with a 2-cycle gap.
- **Timeout:** Req=16'h0100 held, Done=0 -> Grant=16'h0100 for exactly 8 cycles, then Timeout=1 for 1 cycle in RELEASE. Re-grant to index 8 follows 2 cycles after grant end (Ptr=9 wraps to 8).
- **Simultaneous events:**
  - Done=1 on the 8th GRANT cycle -> Timeout stays 0.
  - Req[grantee] drops with Done=1 in the same cycle -> normal release, Timeout=0.
  - Req[grantee] drops alone on cycle 2 -> release after 2 cycles, Timeout=0.
- **Reset mid-grant:** Reset_n=0 during cycle 4 of a grant to index 6 -> all outputs 0 after that edge with no Timeout pulse. Ptr=0, so a held Req=16'h0041 next grants index 0.
